mvm_feeder: RTL and testbench
=============================

// Module: mvm_feeder
// PURPOSE
// - Upstream controller for the saturating MAC: buffers an MxN signed matrix W and an N-vector x,
//   streams operand pairs into the MAC one row at a time, and returns y = W*x one element per row.
// - Sits between the input stream and the MAC. It clears the MAC before each row and collects
//   the final accumulated value on the output stream.
// PARAMETERS
// - M        4   matrix rows / number of output elements
// - N        4   matrix columns / vector length (dot-product length)
// - W        12  operand width, signed
// - ACC_W    24  MAC accumulator width, signed
// PORTS
// - clk            in   1      clock
// - reset          in   1      synchronous, active-high reset
// - s_data         in   W      input word (signed)
// - s_valid        in   1      input word valid
// - s_ready        out  1      block accepts an input word
// - mac_a          out  W      MAC operand a = W[r][k]
// - mac_b          out  W      MAC operand b = x[k]
// - mac_valid      out  1      MAC valid_in
// - mac_clr        out  1      drives MAC reset; clears accumulator and MAC valid pipe
// - mac_f          in   ACC_W  MAC accumulated (saturated) result
// - mac_valid_out  in   1      MAC result valid, one pulse per issued pair
// - m_data         out  ACC_W  y[r]
// - m_valid        out  1      y[r] valid
// - m_ready        in   1      consumer accepts y[r]
// BEHAVIOUR
// - Transfers: input on s_valid&s_ready; output on m_valid&m_ready. No combinational path from
//   s_valid to s_ready or from m_ready to m_valid.
// - States:
//   - LOAD_W: s_ready=1. Takes M*N words in row-major order, W[0][0] first. The last word moves to LOAD_X.
//   - LOAD_X: s_ready=1. Takes N words, x[0] first. The last word moves to CLEAR, with r=0.
//   - CLEAR: mac_clr=1 for exactly 1 cycle, then ISSUE with k=0.
//   - ISSUE: mac_valid=1 for N consecutive cycles with k=0..N-1. mac_a and mac_b are combinational
//     reads of the stored W[r][k] and x[k]. After k=N-1 go to DRAIN.
//   - DRAIN: counts mac_valid_out pulses since CLEAR, including any that arrive during ISSUE.
//     On the N-th pulse: register mac_f into m_data and go to OUT.
//   - OUT: m_valid=1 and m_data is held stable until the handshake. On handshake, r increments.
//     If r was M-1, go to LOAD_W; otherwise go to CLEAR.
// - mac_valid, mac_clr, s_ready and m_valid are never high outside the states listed above.
// - Arithmetic: no arithmetic in this block. Saturation is done by the MAC. m_data is mac_f
//   with no modification.
// - Row timing: 1 (CLEAR) + N (ISSUE) + 4-cycle MAC latency, then OUT. The issue phase of the next
//   row does not overlap the previous row.
// - Reset, at any time including mid-row: state=LOAD_W; r, k, load and pulse counters=0.
//   s_ready=0 during reset and 1 on the first cycle after it. mac_valid=0, mac_clr=0, m_valid=0,
//   m_data=0, mac_a=mac_b=0. Stored W and x contents are not cleared.
// - Boundary rules:
//   - s_valid is ignored outside the load states.
//   - m_ready is ignored outside OUT.
//   - A mac_valid_out pulse in any state other than ISSUE or DRAIN is ignored.
//   - The load counter wraps exactly at M*N-1 or N-1 without overflow.
// CONFIGURATION
// - MVM_MATRIX_HOLD_EN defined: after the last row's handshake, go to LOAD_X. W is kept, and the
//   next job supplies only N new vector words. Reset still goes to LOAD_W.
// - MVM_MATRIX_HOLD_EN undefined: after the last row, go to LOAD_W (a full reload every job).
// STRUCTURE
// - Package mvm_pkg holds:
//   - typedef enum logic [2:0] {LOAD_W, LOAD_X, CLEAR, ISSUE, DRAIN, OUT} mvm_state_t
//   - localparams for default M, N, W, ACC_W and MAC_LAT=4
//   - typedefs operand_t (signed [W-1:0]) and acc_t (signed [ACC_W-1:0])
// - One sub-module, mvm_regfile, with DEPTH and W parameters:
//   - synchronous write, combinational read
//   - instantiated twice: DEPTH=M*N for W, DEPTH=N for x
// - The top level holds the FSM, counters and output register.
// TESTING (M=N=4, W=12, ACC_W=24, bench MAC = saturating 4-cycle MAC)
// - Reset: hold reset 3 cycles. Expect all outputs 0. s_ready=1 on the first cycle after reset is released.
// - Identity: W=I4, x=[1,2,3,4]. Expect y=1,2,3,4. Each row shows mac_clr, 4 mac_valid cycles, then m_valid.
// - Signed/saturation:
//   - all W=2047 and all x=2047: expect y=8388607 for every row.
//   - all W=-2048 and all x=2047: expect y=-8388608 for every row.
// - Backpressure: hold m_ready=0 for 6 cycles in OUT. Expect m_data and m_valid stable and mac_valid=0
//   throughout. On the handshake, the next row's mac_clr appears the following cycle.
// - Input gaps: s_valid toggling 1,0,1,0 with W row0=[1,-1,2,-2] and x=[5,5,5,5]. Expect y[0]=0.
//   Only handshaken words are stored.
// - Mid-op reset and hold macro:
//   - assert reset during ISSUE of row 1: expect LOAD_W next cycle and no m_valid.
//   - with MVM_MATRIX_HOLD_EN, a second job of 4 x-words gives correct y using the retained W.

Source files
------------

// File: rtl/mvm_pkg.sv
// Shared definitions for the matrix-vector feeder in front of the saturating MAC.
// Contents: FSM state encoding, default geometry and widths, operand/accumulator types.
// Optional feature macro used by mvm_feeder: MVM_MATRIX_HOLD_EN.
package mvm_pkg;

    typedef enum logic [2:0] {
        LOAD_W = 3'd0,
        LOAD_X = 3'd1,
        CLEAR  = 3'd2,
        ISSUE  = 3'd3,
        DRAIN  = 3'd4,
        OUT    = 3'd5
    } mvm_state_t;

    localparam int MVM_M     = 4;   // matrix rows / output elements
    localparam int MVM_N     = 4;   // matrix columns / vector length
    localparam int MVM_W     = 12;  // operand width
    localparam int MVM_ACC_W = 24;  // MAC accumulator width
    localparam int MAC_LAT   = 4;   // MAC valid_in -> valid_out latency

    typedef logic signed [MVM_W-1:0]     operand_t;
    typedef logic signed [MVM_ACC_W-1:0] acc_t;

endpackage

// File: rtl/mvm_regfile.sv
// Small operand store: synchronous write, combinational read, no reset on contents.
// Ports:
//   clk            clock
//   we/waddr/wdata write port (captured on the rising edge)
//   raddr/rdata    asynchronous read port
module mvm_regfile #(
    parameter int DEPTH = 4,
    parameter int W     = 12,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write port; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port feeds the MAC operands directly in the same cycle.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/mvm_feeder.sv
// Matrix-vector feeder: buffers an MxN matrix and an N-vector from one input stream, feeds
// operand pairs to an external saturating MAC one row at a time, and returns y = W*x.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   s_data/valid/ready  input word stream (matrix row-major, then vector)
//   mac_a/b/valid/clr   MAC operand pair, valid_in and accumulator clear
//   mac_f/valid_out     MAC accumulated result and its per-pair valid pulse
//   m_data/valid/ready  result stream, one y[r] per row
// Optional feature: define MVM_MATRIX_HOLD_EN to keep the matrix between jobs, so each job
// after the first supplies only the N vector words.
module mvm_feeder
    import mvm_pkg::*;
#(
    parameter int M     = MVM_M,
    parameter int N     = MVM_N,
    parameter int W     = MVM_W,
    parameter int ACC_W = MVM_ACC_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [W-1:0]     s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic signed [W-1:0]     mac_a,
    output logic signed [W-1:0]     mac_b,
    output logic                    mac_valid,
    output logic                    mac_clr,
    input  logic signed [ACC_W-1:0] mac_f,
    input  logic                    mac_valid_out,
    output logic signed [ACC_W-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready
);

    localparam int WD  = M * N;
    localparam int WAW = (WD > 1) ? $clog2(WD) : 1;
    localparam int XAW = (N > 1) ? $clog2(N) : 1;
    localparam int RW  = (M > 1) ? $clog2(M) : 1;
    localparam int PW  = $clog2(N + 1);

`ifdef MVM_MATRIX_HOLD_EN
    localparam mvm_state_t JOB_DONE_STATE = LOAD_X;
`else
    localparam mvm_state_t JOB_DONE_STATE = LOAD_W;
`endif

    mvm_state_t     state;
    mvm_state_t     next_state;
    logic [WAW-1:0] load_cnt;
    logic [XAW-1:0] k;
    logic [RW-1:0]  r;
    logic [PW-1:0]  pulse_cnt;

    logic           s_fire;
    logic           m_fire;
    logic           w_we;
    logic           x_we;
    logic           pulse;
    logic           last_w;
    logic           last_x;
    logic           last_k;
    logic           last_r;
    logic           last_pulse;
    logic [WAW-1:0] w_raddr;
    logic [W-1:0]   w_rdata;
    logic [W-1:0]   x_rdata;

    mvm_regfile #(.DEPTH(WD), .W(W)) u_wmem (
        .clk   (clk),
        .we    (w_we),
        .waddr (load_cnt),
        .wdata (s_data),
        .raddr (w_raddr),
        .rdata (w_rdata)
    );

    mvm_regfile #(.DEPTH(N), .W(W)) u_xmem (
        .clk   (clk),
        .we    (x_we),
        .waddr (XAW'(load_cnt)),
        .wdata (s_data),
        .raddr (k),
        .rdata (x_rdata)
    );

    // Handshake qualifiers and end-of-count flags; s_ready only rises in load states.
    always_comb begin
        s_fire     = s_valid & s_ready;
        m_fire     = m_valid & m_ready;
        w_we       = s_fire & (state == LOAD_W);
        x_we       = s_fire & (state == LOAD_X);
        pulse      = mac_valid_out & ((state == ISSUE) || (state == DRAIN));
        last_w     = (load_cnt == WAW'(WD - 1));
        last_x     = (load_cnt == WAW'(N - 1));
        last_k     = (k == XAW'(N - 1));
        last_r     = (r == RW'(M - 1));
        last_pulse = pulse & (pulse_cnt == PW'(N - 1));
        w_raddr    = WAW'(r) * WAW'(N) + WAW'(k);
    end

    // Operands are gated by mac_valid so they read as zero outside ISSUE and during reset.
    always_comb begin
        if (mac_valid) begin
            mac_a = w_rdata;
            mac_b = x_rdata;
        end else begin
            mac_a = '0;
            mac_b = '0;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            LOAD_W: begin
                if (s_fire && last_w) next_state = LOAD_X;
                else                  next_state = LOAD_W;
            end
            LOAD_X: begin
                if (s_fire && last_x) next_state = CLEAR;
                else                  next_state = LOAD_X;
            end
            CLEAR: begin
                next_state = ISSUE;
            end
            ISSUE: begin
                if (last_k) next_state = DRAIN;
                else        next_state = ISSUE;
            end
            DRAIN: begin
                if (last_pulse) next_state = OUT;
                else            next_state = DRAIN;
            end
            OUT: begin
                if (m_fire && last_r) next_state = JOB_DONE_STATE;
                else if (m_fire)      next_state = CLEAR;
                else                  next_state = OUT;
            end
            default: begin
                next_state = LOAD_W;
            end
        endcase
    end

    // State register plus control outputs registered from the next state, so each output
    // matches its state decode and is forced low while reset is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= LOAD_W;
            s_ready   <= 1'b0;
            mac_clr   <= 1'b0;
            mac_valid <= 1'b0;
            m_valid   <= 1'b0;
        end else begin
            state     <= next_state;
            s_ready   <= (next_state == LOAD_W) || (next_state == LOAD_X);
            mac_clr   <= (next_state == CLEAR);
            mac_valid <= (next_state == ISSUE);
            m_valid   <= (next_state == OUT);
        end
    end

    // Load word counter; shared by both load phases and returned to zero at each phase end.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_cnt <= '0;
        end else if (w_we) begin
            load_cnt <= last_w ? '0 : load_cnt + WAW'(1);
        end else if (x_we) begin
            load_cnt <= last_x ? '0 : load_cnt + WAW'(1);
        end
    end

    // Column index during ISSUE and row index advanced on each result handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            k <= '0;
            r <= '0;
        end else begin
            if (state == CLEAR)      k <= '0;
            else if (state == ISSUE) k <= last_k ? '0 : k + XAW'(1);
            if (x_we && last_x)      r <= '0;
            else if ((state == OUT) && m_fire) r <= last_r ? '0 : r + RW'(1);
        end
    end

    // MAC result pulses counted since the last clear; the N-th one carries the row result.
    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_cnt <= '0;
            m_data    <= '0;
        end else begin
            if (state == CLEAR) pulse_cnt <= '0;
            else if (pulse)     pulse_cnt <= pulse_cnt + PW'(1);
            if ((state == DRAIN) && last_pulse) m_data <= mac_f;
        end
    end

endmodule

// File: tb/tb_mvm_feeder.sv
// Self-checking bench for mvm_feeder with a saturating 4-cycle MAC model attached.
// Expected results come from a plain dot-product reference with per-step saturation.
`timescale 1ns/1ps
module tb_mvm_feeder;

    localparam int M = 4;
    localparam int N = 4;
    localparam longint SAT_MAX = 64'sd8388607;
    localparam longint SAT_MIN = -64'sd8388608;

    logic               clk;
    logic               reset;
    logic signed [11:0] s_data;
    logic               s_valid;
    logic               s_ready;
    logic signed [11:0] mac_a;
    logic signed [11:0] mac_b;
    logic               mac_valid;
    logic               mac_clr;
    logic signed [23:0] mac_f;
    logic               mac_valid_out;
    logic signed [23:0] m_data;
    logic               m_valid;
    logic               m_ready;

    int total = 0;
    int bad   = 0;
    int clr_tot = 0;
    int val_tot = 0;
    int clr_base = 0;
    int val_base = 0;
    int wm [M*N];
    int xv [N];

    mvm_feeder dut (
        .clk           (clk),
        .reset         (reset),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .mac_a         (mac_a),
        .mac_b         (mac_b),
        .mac_valid     (mac_valid),
        .mac_clr       (mac_clr),
        .mac_f         (mac_f),
        .mac_valid_out (mac_valid_out),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Saturating MAC: product pipeline of 3 stages, accumulate on the 4th edge.
    logic signed [23:0] p0, p1, p2, acc;
    logic               v0, v1, v2, vout;
    always @(posedge clk) begin
        if (reset || mac_clr) begin
            v0 <= 1'b0; v1 <= 1'b0; v2 <= 1'b0; vout <= 1'b0;
            p0 <= '0;   p1 <= '0;   p2 <= '0;   acc  <= '0;
        end else begin
            v0 <= mac_valid;
            p0 <= 24'(longint'(mac_a) * longint'(mac_b));
            v1 <= v0; p1 <= p0;
            v2 <= v1; p2 <= p1;
            vout <= v2;
            if (v2) acc <= 24'(sat(longint'(acc) + longint'(p2)));
        end
    end
    assign mac_f         = acc;
    assign mac_valid_out = vout;

    // Activity counters for per-row clear/issue checks.
    always @(posedge clk) begin
        clr_tot <= clr_tot + int'(mac_clr);
        val_tot <= val_tot + int'(mac_valid);
    end

    function automatic longint sat(input longint v);
        if (v > SAT_MAX) return SAT_MAX;
        if (v < SAT_MIN) return SAT_MIN;
        return v;
    endfunction

    function automatic longint ref_y(input int row);
        longint a = 0;
        for (int c = 0; c < N; c++) a = sat(a + longint'(wm[row*N + c]) * longint'(xv[c]));
        return a;
    endfunction

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Offer one word after 'gap' idle cycles with junk on the data bus.
    task automatic push(input int d, input int gap);
        int guard = 0;
        repeat (gap) begin
            s_valid = 1'b0;
            s_data  = 12'($urandom);
            @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = 12'(d);
        while (!s_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("push_timeout", 0, 1);
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = 12'($urandom);
    endtask

    task automatic collect_row(input int row, input int hold, input bit last);
        int guard = 0;
        int unstable = 0;
        logic signed [23:0] held;
        while (!m_valid && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("out_timeout", longint'(guard < 300), 1);
        check($sformatf("clr_count_r%0d", row), clr_tot - clr_base, row + 1);
        check($sformatf("issue_count_r%0d", row), val_tot - val_base, (row + 1) * N);
        held = m_data;
        repeat (hold) begin
            @(negedge clk);
            if (!m_valid || m_data !== held || mac_valid) unstable++;
        end
        check("hold_stable", unstable, 0);
        check($sformatf("y%0d", row), m_data, ref_y(row));
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        if (!last) check("clr_after_hs", mac_clr, 1);
        else       check("ready_after_job", s_ready, 1);
    endtask

    function automatic int gap_of(input int mode, input int i);
        if (mode == 1) return i % 2;
        if (mode == 2) return int'($urandom_range(2));
        return 0;
    endfunction

    // hold < 0 picks a random backpressure length per row.
    task automatic run_job(input bit load_w, input int gap_mode, input int hold);
`ifdef MVM_MATRIX_HOLD_EN
        if (load_w) do_reset(2);
`endif
        clr_base = clr_tot;
        val_base = val_tot;
        if (load_w) for (int i = 0; i < M*N; i++) push(wm[i], gap_of(gap_mode, i));
        for (int i = 0; i < N; i++) push(xv[i], gap_of(gap_mode, i));
        for (int rr = 0; rr < M; rr++)
            collect_row(rr, (hold < 0) ? int'($urandom_range(5)) : hold, rr == M - 1);
    endtask

    task automatic randomize_operands();
        for (int i = 0; i < M*N; i++) wm[i] = int'($urandom_range(4095)) - 2048;
        for (int i = 0; i < N; i++)   xv[i] = int'($urandom_range(4095)) - 2048;
    endtask

    initial begin
        int guard;
        int mv_seen;
        reset = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_mac_valid", mac_valid, 0);
        check("rst_mac_clr", mac_clr, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_mac_a", mac_a, 0);
        check("rst_mac_b", mac_b, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_s_ready", s_ready, 1);

        // Identity matrix with 6-cycle backpressure on every row.
        for (int i = 0; i < M*N; i++) wm[i] = (i / N == i % N) ? 1 : 0;
        for (int i = 0; i < N; i++) xv[i] = i + 1;
        run_job(1'b1, 0, 6);

        // Positive and negative saturation.
        for (int i = 0; i < M*N; i++) wm[i] = 2047;
        for (int i = 0; i < N; i++) xv[i] = 2047;
        run_job(1'b1, 0, 0);
        for (int i = 0; i < M*N; i++) wm[i] = -2048;
        run_job(1'b1, 0, 1);

        // Alternating input gaps; row 0 cancels to zero.
        randomize_operands();
        wm[0] = 1; wm[1] = -1; wm[2] = 2; wm[3] = -2;
        for (int i = 0; i < N; i++) xv[i] = 5;
        run_job(1'b1, 1, -1);

        // Random jobs with random gaps and backpressure.
        for (int j = 0; j < 3; j++) begin
            randomize_operands();
            run_job(1'b1, 2, -1);
        end

        // Reset during the issue phase of row 1.
        randomize_operands();
`ifdef MVM_MATRIX_HOLD_EN
        do_reset(2);
`endif
        clr_base = clr_tot;
        val_base = val_tot;
        for (int i = 0; i < M*N; i++) push(wm[i], 0);
        for (int i = 0; i < N; i++) push(xv[i], 0);
        collect_row(0, 0, 1'b0);
        guard = 0;
        while (!mac_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("row1_issue_seen", mac_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_mac_valid", mac_valid, 0);
        check("midrst_m_valid", m_valid, 0);
        check("midrst_s_ready", s_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_load_w", s_ready, 1);
        mv_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (m_valid || mac_valid) mv_seen++;
        end
        check("midrst_quiet", mv_seen, 0);

        // Full reload after the aborted job must work from LOAD_W.
        randomize_operands();
        clr_base = clr_tot;
        val_base = val_tot;
        for (int i = 0; i < M*N; i++) push(wm[i], gap_of(2, i));
        for (int i = 0; i < N; i++) push(xv[i], gap_of(2, i));
        for (int rr = 0; rr < M; rr++) collect_row(rr, int'($urandom_range(3)), rr == M - 1);

`ifdef MVM_MATRIX_HOLD_EN
        // Second job supplies only a new vector; the matrix is retained.
        for (int i = 0; i < N; i++) xv[i] = int'($urandom_range(4095)) - 2048;
        run_job(1'b0, 2, -1);
`else
        randomize_operands();
        run_job(1'b1, 2, -1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got=1 expected=0");
        $fatal(1, "timeout");
    end

endmodule
